// File: rtl/phy_pkg.sv
// Shared rx/tx PHY definitions: lane count, byte width and the un-striper FSM encoding.
package phy_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned PTR_W     = $clog2(NUM_LANES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } rx_state_e;

endpackage

// File: rtl/demux_idle_timer.sv
// Counts consecutive idle cycles while a partial group is held; strobes timeout on the
// cycle the stall limit is reached so the caller can drop the partial group.
module demux_idle_timer #(
    parameter int unsigned IDLE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic timeout
);

    localparam int unsigned     CNT_W    = $clog2(IDLE_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_MAX - 1);

    logic [CNT_W-1:0] r_idle_cnt;

    assign timeout = tick && (r_idle_cnt == CNT_LAST);

    // Wrapping to zero on timeout means the counter never exceeds IDLE_MAX-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idle_cnt <= '0;
        end else if (clear || timeout) begin
            r_idle_cnt <= '0;
        end else if (tick) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/demux_1x4_8bits.sv
// Receive-side lane un-striper: deals valid bytes round-robin into 4 lanes and presents
// each completed group with a 1-cycle valid_out pulse; stalled partial groups are dropped.
module demux_1x4_8bits
    import phy_pkg::*;
#(
    parameter int unsigned WIDTH    = BYTE_W,
    parameter int unsigned IDLE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             valid_out,
    output logic             dropped
);

    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_LANES - 1);

    rx_state_e        r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_buf0;
    logic [WIDTH-1:0] r_buf1;
    logic [WIDTH-1:0] r_buf2;

    logic w_tick;
    logic w_clear;
    logic w_timeout;

    assign w_tick  = (r_state == ST_FILL) && !valid_in;
    assign w_clear = valid_in || (r_state == ST_IDLE);

    demux_idle_timer #(
        .IDLE_MAX (IDLE_MAX)
    ) u_idle_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .tick    (w_tick),
        .timeout (w_timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_buf0    <= '0;
            r_buf1    <= '0;
            r_buf2    <= '0;
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            valid_out <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            dropped   <= 1'b0;
            if (valid_in) begin
                if (r_ptr == LAST_LANE) begin
                    // Last lane bypasses the buffer so the group is visible right after its edge.
                    out0      <= r_buf0;
                    out1      <= r_buf1;
                    out2      <= r_buf2;
                    out3      <= data_in;
                    valid_out <= 1'b1;
                    r_ptr     <= '0;
                    r_state   <= ST_IDLE;
                end else begin
                    case (r_ptr)
                        PTR_W'(0): r_buf0 <= data_in;
                        PTR_W'(1): r_buf1 <= data_in;
                        default:   r_buf2 <= data_in;
                    endcase
                    r_ptr   <= r_ptr + 1'b1;
                    r_state <= ST_FILL;
                end
            end else if (w_timeout) begin
                r_ptr   <= '0;
                r_state <= ST_IDLE;
                dropped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_1x4_8bits.sv
// Self-checking bench for demux_1x4_8bits: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based model of the group/timeout rules.
module tb_demux_1x4_8bits;

    localparam int unsigned IDLE_MAX = 4;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic [7:0] out0, out1, out2, out3;
    logic       valid_out;
    logic       dropped;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] pend_q[$];
    int         idle_run;
    logic [7:0] exp_out[4];
    logic       exp_vo;
    logic       exp_dr;

    demux_1x4_8bits #(
        .WIDTH    (8),
        .IDLE_MAX (IDLE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .valid_out (valid_out),
        .dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".out0"}, {24'd0, out0}, {24'd0, exp_out[0]});
        check_eq({tag, ".out1"}, {24'd0, out1}, {24'd0, exp_out[1]});
        check_eq({tag, ".out2"}, {24'd0, out2}, {24'd0, exp_out[2]});
        check_eq({tag, ".out3"}, {24'd0, out3}, {24'd0, exp_out[3]});
        check_eq({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, exp_vo});
        check_eq({tag, ".dropped"}, {31'd0, dropped}, {31'd0, exp_dr});
    endtask

    task automatic model_clear();
        pend_q.delete();
        idle_run = 0;
        exp_vo   = 1'b0;
        exp_dr   = 1'b0;
        for (int i = 0; i < 4; i++) exp_out[i] = 8'h00;
    endtask

    // One clock: drive inputs, advance the model at the edge, check #1 later.
    task automatic step(input string tag, input logic v, input logic [7:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk);
        exp_vo = 1'b0;
        exp_dr = 1'b0;
        if (v) begin
            pend_q.push_back(d);
            idle_run = 0;
            if (pend_q.size() == 4) begin
                for (int i = 0; i < 4; i++) exp_out[i] = pend_q[i];
                pend_q.delete();
                exp_vo = 1'b1;
            end
        end else if (pend_q.size() > 0) begin
            idle_run++;
            if (idle_run == IDLE_MAX) begin
                pend_q.delete();
                idle_run = 0;
                exp_dr   = 1'b1;
            end
        end
        #1;
        check_all(tag);
    endtask

    // Assert reset between edges and confirm outputs clear without any clock edge.
    task automatic async_reset(input string tag);
        valid_in = 1'b0;
        data_in  = 8'h00;
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check_all(tag);
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        model_clear();
        #1;
        check_all("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single group
        step("grp", 1'b1, 8'hA0);
        step("grp", 1'b1, 8'hB1);
        step("grp", 1'b1, 8'hC2);
        step("grp", 1'b1, 8'hD3);
        step("grp.after", 1'b0, 8'h00);

        // Async reset with a non-zero group held on the outputs
        step("pre_rst", 1'b1, 8'h5A);
        async_reset("rst_async");

        // Back-to-back groups, no bubble
        for (int i = 0; i < 8; i++) step("b2b", 1'b1, 8'(i));
        step("b2b.after", 1'b0, 8'h00);

        // Gaps just under the limit
        step("gap", 1'b1, 8'h11);
        step("gap", 1'b1, 8'h22);
        for (int i = 0; i < 3; i++) step("gap.idle", 1'b0, 8'hFF);
        step("gap", 1'b1, 8'h33);
        step("gap", 1'b1, 8'h44);

        // Timeout drops the partial group, outputs hold
        step("to", 1'b1, 8'h55);
        step("to", 1'b1, 8'h66);
        for (int i = 0; i < 4; i++) step("to.idle", 1'b0, 8'hEE);
        step("to.after", 1'b0, 8'h00);
        for (int i = 1; i <= 4; i++) step("to.next", 1'b1, 8'(i));

        // Byte arriving on the would-be timeout cycle is accepted
        step("edge", 1'b1, 8'hC0);
        for (int i = 0; i < 3; i++) step("edge.idle", 1'b0, 8'h00);
        step("edge", 1'b1, 8'hC1);
        step("edge", 1'b1, 8'hC2);
        step("edge", 1'b1, 8'hC3);

        // Idle with nothing held never drops
        for (int i = 0; i < 6; i++) step("idle", 1'b0, 8'h00);

        // Reset mid-group loses the partial silently
        step("rmid", 1'b1, 8'h77);
        step("rmid", 1'b1, 8'h88);
        async_reset("rmid.rst");
        step("rmid", 1'b1, 8'h9A);
        step("rmid", 1'b1, 8'h9B);
        step("rmid", 1'b1, 8'h9C);
        step("rmid", 1'b1, 8'h9D);
        step("rmid.after", 1'b0, 8'h00);

        // Randomized traffic with bursty idle phases and rare resets
        for (int n = 0; n < 600; n++) begin
            int unsigned dens;
            dens = (n / 50) % 3;
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rnd.rst");
            end else begin
                logic v;
                v = (dens == 0) ? 1'b1 : (dens == 1) ? ($urandom_range(0, 3) != 0)
                                                     : ($urandom_range(0, 2) == 0);
                step("rnd", v, 8'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
